// File: rtl/matmul_result_buffer.sv
// Captures a finished matrix-multiply result into one of several scratchpad slots,
// one element per cycle, and serves element reads plus a full-slot view of any slot.
module matmul_result_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int NELEM      = MAX_DIM * MAX_DIM
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       finish_mul_i,
    input  logic [NELEM*BUS_WIDTH-1:0] c_matrix_i,
    input  logic [NELEM-1:0]           flags_i,
    input  logic [1:0]                 wr_slot_i,
    input  logic [1:0]                 rd_slot_i,
    input  logic                       rd_req_i,
    input  logic [3:0]                 rd_addr_i,
    output logic                       rd_ready_o,
    output logic [BUS_WIDTH-1:0]       rd_data_o,
    output logic                       rd_valid_o,
    output logic [NELEM*BUS_WIDTH-1:0] c_matrix_o,
    output logic [NELEM-1:0]           flags_o,
    output logic                       finish_write_o,
    output logic                       busy_o,
    output logic                       dropped_o
);
    localparam int CW = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int SW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_fw_next;
    logic                       r_finish_write;
    logic                       r_fin_prev;
    logic                       r_armed;
    logic                       r_dropped;
    logic [NELEM*BUS_WIDTH-1:0] r_sh_data;
    logic [NELEM-1:0]           r_sh_flags;
    logic [SW-1:0]              r_sh_slot;
    logic [CW-1:0]              r_cnt;
    logic [BUS_WIDTH-1:0]       r_mem [SP_NTARGETS][NELEM];
    logic [NELEM-1:0]           r_flags [SP_NTARGETS];
    logic                       r_rd_valid;
    logic [BUS_WIDTH-1:0]       r_rd_data;

    logic                       w_rise;
    logic                       w_last;
    logic                       w_slot_ok;
    logic                       w_addr_ok;
    logic [SW-1:0]              w_rd_slot;
    logic [CW-1:0]              w_rd_addr;
    logic [BUS_WIDTH-1:0]       w_sh_elem;

    // r_armed stays low after reset until finish_mul_i has been seen low, so a
    // level still high from before reset cannot masquerade as a new edge.
    assign w_rise    = finish_mul_i & ~r_fin_prev & r_armed;
    assign w_last    = (32'(r_cnt) == NELEM - 1);
    assign w_slot_ok = (32'(rd_slot_i) < SP_NTARGETS);
    assign w_addr_ok = (32'(rd_addr_i) < NELEM);
    assign w_rd_slot = rd_slot_i[SW-1:0];
    assign w_rd_addr = rd_addr_i[CW-1:0];
    assign w_sh_elem = r_sh_data[32'(r_cnt)*BUS_WIDTH +: BUS_WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_finish_write <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_finish_write <= w_fw_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fw_next    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_next = S_WRITE;
            S_WRITE: if (w_last) begin
                         w_state_next = S_DONE;
                         w_fw_next    = 1'b1;
                     end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fin_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_dropped  <= 1'b0;
            r_sh_data  <= '0;
            r_sh_flags <= '0;
            r_sh_slot  <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            for (int s = 0; s < SP_NTARGETS; s++) begin
                r_flags[s] <= '0;
                for (int e = 0; e < NELEM; e++) r_mem[s][e] <= '0;
            end
        end else begin
            r_fin_prev <= finish_mul_i;
            r_armed    <= r_armed | ~finish_mul_i;
            if (w_rise && r_state != S_IDLE) r_dropped <= 1'b1;
            if (w_rise && r_state == S_IDLE) begin
                r_sh_data  <= c_matrix_i;
                r_sh_flags <= flags_i;
                r_sh_slot  <= wr_slot_i[SW-1:0] & SW'(SP_NTARGETS - 1);
                r_cnt      <= '0;
            end
            if (r_state == S_WRITE) begin
                r_mem[r_sh_slot][r_cnt] <= w_sh_elem;
                r_cnt                   <= r_cnt + 1'b1;
                if (w_last) r_flags[r_sh_slot] <= r_sh_flags;
            end
            r_rd_valid <= (r_state == S_IDLE) && rd_req_i;
            if (r_state == S_IDLE && rd_req_i)
                r_rd_data <= (w_slot_ok && w_addr_ok) ? r_mem[w_rd_slot][w_rd_addr] : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NELEM; gi++) begin : g_cview
            assign c_matrix_o[(gi+1)*BUS_WIDTH-1 -: BUS_WIDTH] =
                w_slot_ok ? r_mem[w_rd_slot][gi] : '0;
        end
    endgenerate

    assign flags_o        = w_slot_ok ? r_flags[w_rd_slot] : '0;
    assign rd_ready_o     = (r_state == S_IDLE);
    assign busy_o         = (r_state != S_IDLE);
    assign finish_write_o = r_finish_write;
    assign rd_valid_o     = r_rd_valid;
    assign rd_data_o      = r_rd_data;
    assign dropped_o      = r_dropped;
endmodule
